// File: rtl/schmidl_cox_preamble_inserter_if.sv
// AXI-stream style sample channel shared by the input and output sides of the
// preamble inserter. Samples are packed {I[31:16], Q[15:0]}.
interface schmidl_cox_preamble_inserter_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/schmidl_cox_preamble_inserter.sv
// Prepends every OFDM frame with a Schmidl-Cox training symbol: a stored
// half-length sequence played twice, followed by the payload passed through.
module schmidl_cox_preamble_inserter #(
  parameter  int unsigned FFT_SIZE      = 1024,
  localparam int unsigned HALF_FFT_SIZE = FFT_SIZE / 2,
  localparam int unsigned ADDR_W        = $clog2(HALF_FFT_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  preamble_en,
  input  logic                  cfg_wr_en,
  input  logic [ADDR_W-1:0]     cfg_wr_addr,
  input  logic [31:0]           cfg_wr_data,
  output logic                  cfg_busy,
  schmidl_cox_preamble_inserter_if.slave  i_axis,
  schmidl_cox_preamble_inserter_if.master o_axis,
  output logic [15:0]           frame_count
);

  localparam int unsigned FIDX_W = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, PRE_A, PRE_B, PAYLOAD} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [FIDX_W-1:0]   fidx;
  logic [ADDR_W-1:0]   rd_addr;
  logic [31:0]         rd_data;
  logic                rd_valid;
  logic                rd_en;
  logic                ld_ram;
  logic                ld_in;
  logic                in_ready;
  logic                wr_ok;

  logic [31:0]         o_data_r;
  logic                o_last_r;
  logic                o_valid_r;
  logic                o_is_pre;

  logic                adv;
  logic                out_acc;
  logic                pre_acc;
  logic                pre_last;
  logic                fetch_more;

  logic [31:0]         ram [HALF_FFT_SIZE];

  assign cfg_busy   = (state != IDLE);
  assign adv        = ~o_valid_r | o_axis.tready;
  assign out_acc    = o_valid_r & o_axis.tready;
  assign pre_acc    = out_acc & o_is_pre;
  assign pre_last   = (cnt == '1);
  assign fetch_more = (fidx != FIDX_W'(FFT_SIZE));
  assign rd_addr    = (state == IDLE) ? '0 : fidx[ADDR_W-1:0];
  assign wr_ok      = cfg_wr_en & ~cfg_busy & ~clear;

  assign o_axis.tdata  = o_data_r;
  assign o_axis.tlast  = o_last_r;
  assign o_axis.tvalid = o_valid_r;
  assign i_axis.tready = in_ready;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    ld_ram    = 1'b0;
    ld_in     = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (i_axis.tvalid) begin
          if (preamble_en) begin
            state_nxt = PRE_A;
            rd_en     = 1'b1;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PRE_A, PRE_B: begin
        // Fetch runs one sample ahead of the output register so the A/B seam
        // and the hand-over to payload carry no bubble.
        ld_ram = adv & rd_valid;
        rd_en  = fetch_more & (~rd_valid | ld_ram);
        if (state == PRE_A && pre_acc && pre_last)
          state_nxt = PRE_B;
        if (state == PRE_B && o_valid_r && o_is_pre && pre_last) begin
          in_ready = o_axis.tready & ~clear;
          ld_in    = in_ready & i_axis.tvalid;
          if (o_axis.tready)
            state_nxt = (ld_in & i_axis.tlast) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        in_ready = adv & ~clear;
        ld_in    = in_ready & i_axis.tvalid;
        if (ld_in & i_axis.tlast)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      ram[cfg_wr_addr] <= cfg_wr_data;
    if (rd_en)
      rd_data <= (wr_ok && cfg_wr_addr == rd_addr) ? cfg_wr_data : ram[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      fidx        <= '0;
      rd_valid    <= 1'b0;
      o_data_r    <= '0;
      o_last_r    <= 1'b0;
      o_valid_r   <= 1'b0;
      o_is_pre    <= 1'b0;
      frame_count <= '0;
    end else if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      fidx        <= '0;
      rd_valid    <= 1'b0;
      o_data_r    <= '0;
      o_last_r    <= 1'b0;
      o_valid_r   <= 1'b0;
      o_is_pre    <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE)
        fidx <= rd_en ? FIDX_W'(1) : '0;
      else if (rd_en)
        fidx <= fidx + 1'b1;

      if (rd_en)
        rd_valid <= 1'b1;
      else if (ld_ram)
        rd_valid <= 1'b0;

      if ((state == PRE_A || state == PRE_B) && pre_acc)
        cnt <= pre_last ? '0 : cnt + 1'b1;

      if (ld_ram) begin
        o_data_r  <= rd_data;
        o_last_r  <= 1'b0;
        o_valid_r <= 1'b1;
        o_is_pre  <= 1'b1;
      end else if (ld_in) begin
        o_data_r  <= i_axis.tdata;
        o_last_r  <= i_axis.tlast;
        o_valid_r <= 1'b1;
        o_is_pre  <= 1'b0;
      end else if (out_acc) begin
        o_last_r  <= 1'b0;
        o_valid_r <= 1'b0;
        o_is_pre  <= 1'b0;
      end

      if (out_acc && o_last_r)
        frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Scoreboard bench for the Schmidl-Cox preamble inserter at FFT_SIZE=8.
module tb_schmidl_cox_preamble_inserter;
  localparam int unsigned FFT_SIZE = 8;
  localparam int unsigned HALF     = FFT_SIZE / 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        preamble_en;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_busy;
  logic [15:0] frame_count;

  schmidl_cox_preamble_inserter_if in_if ();
  schmidl_cox_preamble_inserter_if out_if ();

  schmidl_cox_preamble_inserter #(.FFT_SIZE(FFT_SIZE)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .preamble_en (preamble_en),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_busy    (cfg_busy),
    .i_axis      (in_if),
    .o_axis      (out_if),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad = 0;
  logic [32:0] exp_q [$];
  logic [31:0] exp_ram [HALF];
  int          beats_seen = 0;
  int          exp_fc = 0;
  int          cyc = 0;
  bit          lat_armed = 1'b0;
  int          lat_start = 0;
  int          lat_obs = -1;
  bit          held_v = 1'b0;
  logic [32:0] held;
  bit          toggle = 1'b0;
  bit          abort = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle) out_if.tready = ~out_if.tready;
    end
  end

  // Output monitor: stability under backpressure, then scoreboard compare.
  always @(negedge clk) begin
    if (!reset) begin
      if (held_v)
        chk("hold", {out_if.tvalid, out_if.tlast, out_if.tdata}, {1'b1, held});
      if (lat_armed && out_if.tvalid) begin
        lat_obs   = cyc - lat_start;
        lat_armed = 1'b0;
      end
      if (out_if.tvalid && out_if.tready) begin
        logic [32:0] e;
        beats_seen++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_if.tlast, out_if.tdata}, e);
          if (e[32]) exp_fc++;
        end
      end
      held_v = out_if.tvalid & ~out_if.tready;
      held   = {out_if.tlast, out_if.tdata};
    end
  end

  task automatic cfg_write(input int a, input logic [31:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = a[1:0];
    cfg_wr_data = d;
    step();
    cfg_wr_en   = 1'b0;
    exp_ram[a]  = d;
  endtask

  task automatic send_frame(input bit pre, input int n, input logic [31:0] base, input bit chk_rdy);
    bit acc;
    bit er;
    int g;
    preamble_en = pre;
    if (pre)
      for (int r = 0; r < 2; r++)
        for (int a = 0; a < int'(HALF); a++)
          exp_q.push_back({1'b0, exp_ram[a]});
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == n - 1), base + k});
    for (int k = 0; k < n && !abort; k++) begin
      in_if.tdata  = base + k;
      in_if.tlast  = (k == n - 1);
      in_if.tvalid = 1'b1;
      acc = 1'b0;
      g   = 0;
      while (!acc && !abort && g < 300) begin
        @(negedge clk);
        acc = in_if.tready;
        if (chk_rdy && k > 0) begin
          er = out_if.tready | ~out_if.tvalid;
          chk("i_tready", in_if.tready, er);
        end
        step();
        g++;
      end
      if (!abort) chk("in_accept", acc, 1);
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      step();
      g++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g;
    reset        = 1'b1;
    clear        = 1'b0;
    preamble_en  = 1'b0;
    cfg_wr_en    = 1'b0;
    cfg_wr_addr  = '0;
    cfg_wr_data  = '0;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    out_if.tready = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_tvalid", out_if.tvalid, 0);
    chk("rst_tlast", out_if.tlast, 0);
    chk("rst_tdata", out_if.tdata, 0);
    chk("rst_i_tready", in_if.tready, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_fc", frame_count, 0);

    for (int a = 0; a < int'(HALF); a++)
      cfg_write(a, 32'h00010002 + a * 32'h00010001);

    // Plain preamble + 3-sample payload, full throughput
    lat_start = cyc;
    lat_armed = 1'b1;
    send_frame(1'b1, 3, 32'hA, 1'b0);
    drain();
    chk("latency_pre", lat_obs, 2);
    chk("fc_t1", frame_count, exp_fc);

    // Same frame under alternating backpressure
    toggle = 1'b1;
    send_frame(1'b1, 3, 32'hA, 1'b0);
    drain();
    toggle = 1'b0;
    out_if.tready = 1'b1;
    chk("fc_t2", frame_count, exp_fc);

    // Pass-through with backpressure and i_tready rule
    toggle = 1'b1;
    lat_start = cyc;
    lat_armed = 1'b1;
    send_frame(1'b0, 5, 32'h100, 1'b1);
    drain();
    toggle = 1'b0;
    out_if.tready = 1'b1;
    chk("latency_pass", lat_obs, 2);
    chk("fc_t3", frame_count, exp_fc);

    // cfg write during PRE_B must be dropped
    fork
      send_frame(1'b1, 3, 32'h10, 1'b0);
      begin
        base = beats_seen;
        g = 0;
        while (beats_seen < base + 5 && g < 100) begin
          step();
          g++;
        end
        chk("reach_pre_b", beats_seen - base, 5);
        chk("busy_pre_b", cfg_busy, 1);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 2'd2;
        cfg_wr_data = 32'hDEADBEEF;
        step();
        cfg_wr_en   = 1'b0;
      end
    join
    drain();
    send_frame(1'b1, 1, 32'h30, 1'b0);
    drain();
    chk("fc_t4", frame_count, exp_fc);

    // Asynchronous reset in PRE_A at cnt=2
    fork
      send_frame(1'b1, 3, 32'h40, 1'b0);
      begin
        base = beats_seen;
        g = 0;
        while (beats_seen < base + 2 && g < 100) begin
          step();
          g++;
        end
        chk("reach_cnt2", beats_seen - base, 2);
        #3;
        abort = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        held_v = 1'b0;
        #1;
        chk("arst_tvalid", out_if.tvalid, 0);
        chk("arst_tlast", out_if.tlast, 0);
        chk("arst_tdata", out_if.tdata, 0);
        chk("arst_i_tready", in_if.tready, 0);
        chk("arst_busy", cfg_busy, 0);
        chk("arst_fc", frame_count, 0);
        exp_fc = 0;
        step();
        step();
        reset = 1'b0;
      end
    join
    abort = 1'b0;
    step();
    send_frame(1'b1, 2, 32'h50, 1'b0);
    drain();
    chk("fc_t5", frame_count, exp_fc);

    // Back-to-back 1-sample frames
    send_frame(1'b1, 1, 32'h60, 1'b0);
    send_frame(1'b1, 1, 32'h61, 1'b0);
    drain();
    chk("fc_t6", frame_count, exp_fc);

    // Synchronous clear keeps RAM contents
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_fc", frame_count, 0);
    chk("clr_tvalid", out_if.tvalid, 0);
    chk("clr_busy", cfg_busy, 0);
    exp_fc = 0;
    send_frame(1'b1, 2, 32'h70, 1'b0);
    drain();
    chk("fc_clr", frame_count, exp_fc);

    // Write to address 0 in the same cycle the frame starts (write-first)
    exp_ram[0] = 32'h12345678;
    fork
      begin
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 2'd0;
        cfg_wr_data = 32'h12345678;
        step();
        cfg_wr_en   = 1'b0;
      end
      send_frame(1'b1, 1, 32'h80, 1'b0);
    join
    drain();
    chk("fc_t7", frame_count, exp_fc);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
